mem_arbiter: RTL and testbench

Two-requester arbiter that shares one unified memory port between the fetch stage (read-only) and the memory stage (load/store), so the pipelined core can run against a single-ported memory. Sits between the core's imem/dmem interfaces and the external memory bus. Performs one transaction at a time: arbitration, registered bus drive, downstream ack wait with timeout, and a one-cycle response pulse.

---
 rtl/mem_arbiter_pkg.sv | 35 +++
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arb_timer.sv | 37 +++
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory-port arbiter.
// Bus widths follow `ADDR_SIZE / `INSTR_SIZE (MSB indices) when defined by the core.
`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 31
`endif

package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = `ADDR_SIZE + 1;
  localparam int unsigned DATA_W = `INSTR_SIZE + 1;

  typedef enum logic [2:0] {
    MEM_ARB_IDLE   = 3'd0,
    MEM_ARB_BUSY_I = 3'd1,
    MEM_ARB_BUSY_D = 3'd2,
    MEM_ARB_RESP_I = 3'd3,
    MEM_ARB_RESP_D = 3'd4
  } arb_state_e;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  // Granted request as driven onto the external bus
  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_bus_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side (fetch/data) and bus-side signals of the memory arbiter.
// slave = arbiter view, master = core + memory environment view.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;

  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              m_req;
  logic              m_we;
  logic [1:0]        m_size;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ack;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_ack, m_rdata,
    output i_ready, i_rdata, i_err, d_ready, d_rdata, d_err,
           m_req, m_we, m_size, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_ack, m_rdata,
    input  i_ready, i_rdata, i_err, d_ready, d_rdata, d_err,
           m_req, m_we, m_size, m_addr, m_wdata
  );

endinterface

// File: rtl/mem_arb_timer.sv
// Loadable down-counter used as the bus-ack timeout; expired while the count is zero.
module mem_arb_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_c
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (read-only) and data (load/store), one transaction at a time.
// Define MEM_ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT back-to-back data grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  if (TIMEOUT < 1 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("mem_arbiter: TIMEOUT and STARVE_LIMIT must both be at least 1");
  end

  arb_state_e        state_q, state_d;
  mem_bus_req_t      breq_q, breq_d;
  logic              m_req_q, m_req_d;
  logic              i_ready_q, i_ready_d;
  logic              i_err_q, i_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              d_ready_q, d_ready_d;
  logic              d_err_q, d_err_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic grant_i, grant_d, force_i, is_d;
  logic tmr_clr, tmr_load, tmr_en, tmr_expired;

  mem_arb_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (TW'(TIMEOUT - 1)),
    .en_i       (tmr_en),
    .expired_c  (tmr_expired)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  // Streak of data grants taken while fetch was waiting
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] streak_q, streak_d;

  assign force_i = bus.i_req && (streak_q == SW'(STARVE_LIMIT));

  always_comb begin
    streak_d = streak_q;
    if (grant_i) begin
      streak_d = '0;
    end else if (grant_d) begin
      streak_d = bus.i_req ? (streak_q + SW'(1)) : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign force_i = 1'b0;
`endif

  assign is_d = (state_q == MEM_ARB_BUSY_D);

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    breq_d    = breq_q;
    m_req_d   = m_req_q;
    i_ready_d = 1'b0;
    i_err_d   = i_err_q;
    i_rdata_d = i_rdata_q;
    d_ready_d = 1'b0;
    d_err_d   = d_err_q;
    d_rdata_d = d_rdata_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    tmr_clr   = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;

    case (state_q)
      MEM_ARB_IDLE: begin
        if (bus.d_req && !force_i) begin
          grant_d  = 1'b1;
          state_d  = MEM_ARB_BUSY_D;
          m_req_d  = 1'b1;
          tmr_load = 1'b1;
          breq_d   = '{we: bus.d_we, size: bus.d_size, addr: bus.d_addr, wdata: bus.d_wdata};
        end else if (bus.i_req) begin
          grant_i  = 1'b1;
          state_d  = MEM_ARB_BUSY_I;
          m_req_d  = 1'b1;
          tmr_load = 1'b1;
          breq_d   = '{we: 1'b0, size: MEM_SIZE_B, addr: bus.i_addr, wdata: '0};
        end
      end

      MEM_ARB_BUSY_I, MEM_ARB_BUSY_D: begin
        if (!m_req_q) begin
          // Timed out last cycle; err/rdata were already latched
          state_d = is_d ? MEM_ARB_RESP_D : MEM_ARB_RESP_I;
          if (is_d) d_ready_d = 1'b1;
          else      i_ready_d = 1'b1;
        end else begin
          tmr_en = 1'b1;
          if (bus.m_ack) begin
            m_req_d = 1'b0;
            state_d = is_d ? MEM_ARB_RESP_D : MEM_ARB_RESP_I;
            if (is_d) begin
              d_ready_d = 1'b1;
              d_rdata_d = bus.m_rdata;
              d_err_d   = 1'b0;
            end else begin
              i_ready_d = 1'b1;
              i_rdata_d = bus.m_rdata;
              i_err_d   = 1'b0;
            end
          end else if (tmr_expired) begin
            m_req_d = 1'b0;
            if (is_d) begin
              d_rdata_d = '0;
              d_err_d   = 1'b1;
            end else begin
              i_rdata_d = '0;
              i_err_d   = 1'b1;
            end
          end
        end
      end

      MEM_ARB_RESP_I, MEM_ARB_RESP_D: begin
        state_d = MEM_ARB_IDLE;
        tmr_clr = 1'b1;
      end

      default: begin
        state_d = MEM_ARB_IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MEM_ARB_IDLE;
      breq_q    <= '0;
      m_req_q   <= 1'b0;
      i_ready_q <= 1'b0;
      i_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_ready_q <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      breq_q    <= breq_d;
      m_req_q   <= m_req_d;
      i_ready_q <= i_ready_d;
      i_err_q   <= i_err_d;
      i_rdata_q <= i_rdata_d;
      d_ready_q <= d_ready_d;
      d_err_q   <= d_err_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = breq_q.we;
  assign bus.m_size  = breq_q.size;
  assign bus.m_addr  = breq_q.addr;
  assign bus.m_wdata = breq_q.wdata;
  assign bus.i_ready = i_ready_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.i_err   = i_err_q;
  assign bus.d_ready = d_ready_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.d_err   = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; responses are predicted into a scoreboard queue and checked on ready.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned TIMEOUT      = 8;
  localparam int unsigned STARVE_LIMIT = 4;

  typedef struct {
    bit                is_d;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare the current ready cycle against the oldest predicted response
  task automatic check_resp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, observed i_ready=%0b d_ready=%0b", tag, bus.i_ready, bus.d_ready);
      return;
    end
    e = sb.pop_front();
    check({tag, "_i_ready"}, 64'(bus.i_ready), 64'(!e.is_d));
    check({tag, "_d_ready"}, 64'(bus.d_ready), 64'(e.is_d));
    check({tag, "_rdata"}, 64'(e.is_d ? bus.d_rdata : bus.i_rdata), 64'(e.rdata));
    check({tag, "_err"}, 64'(e.is_d ? bus.d_err : bus.i_err), 64'(e.err));
  endtask

  initial begin
    bit want_d;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_ack = 1'b0; bus.m_rdata = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_req",   64'(bus.m_req), 64'(0));
    check("rst_m_we",    64'(bus.m_we), 64'(0));
    check("rst_m_size",  64'(bus.m_size), 64'(0));
    check("rst_m_addr",  64'(bus.m_addr), 64'(0));
    check("rst_m_wdata", 64'(bus.m_wdata), 64'(0));
    check("rst_i_ready", 64'(bus.i_ready), 64'(0));
    check("rst_d_ready", 64'(bus.d_ready), 64'(0));
    check("rst_i_err",   64'(bus.i_err), 64'(0));
    check("rst_d_err",   64'(bus.d_err), 64'(0));
    check("rst_i_rdata", 64'(bus.i_rdata), 64'(0));
    check("rst_d_rdata", 64'(bus.d_rdata), 64'(0));
    reset = 1'b1;
    tick();

    // Zero-wait fetch
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    sb.push_back('{1'b0, 32'h0000_0013, 1'b0});
    tick();
    check("f_m_req",  64'(bus.m_req), 64'(1));
    check("f_m_addr", 64'(bus.m_addr), 64'h100);
    check("f_m_we",   64'(bus.m_we), 64'(0));
    check("f_m_size", 64'(bus.m_size), 64'(0));
    bus.m_ack = 1'b1; bus.m_rdata = 32'h0000_0013;
    tick();
    bus.m_ack = 1'b0; bus.m_rdata = '0;
    check("f_m_req_drop", 64'(bus.m_req), 64'(0));
    check_resp("f_resp");
    bus.i_req = 1'b0;
    tick();
    check("f_ready_pulse", 64'(bus.i_ready), 64'(0));
    check("f_rdata_hold",  64'(bus.i_rdata), 64'h13);

    // Simultaneous requests: data first, then fetch
    bus.i_req = 1'b1; bus.i_addr = 32'h200;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = MEM_SIZE_W;
    bus.d_addr = 32'h2000; bus.d_wdata = 32'hDEAD_BEEF;
    sb.push_back('{1'b1, 32'h0000_0055, 1'b0});
    sb.push_back('{1'b0, 32'hCAFE_0001, 1'b0});
    tick();
    check("both_m_we",    64'(bus.m_we), 64'(1));
    check("both_m_wdata", 64'(bus.m_wdata), 64'hDEAD_BEEF);
    check("both_m_addr",  64'(bus.m_addr), 64'h2000);
    check("both_m_size",  64'(bus.m_size), 64'(2));
    bus.m_ack = 1'b1; bus.m_rdata = 32'h0000_0055;
    tick();
    bus.m_ack = 1'b0;
    check_resp("both_d_resp");
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    tick();
    check("both_idle_m_req", 64'(bus.m_req), 64'(0));
    tick();
    check("both_i_m_req",  64'(bus.m_req), 64'(1));
    check("both_i_m_addr", 64'(bus.m_addr), 64'h200);
    check("both_i_m_we",   64'(bus.m_we), 64'(0));
    check("both_i_m_size", 64'(bus.m_size), 64'(0));
    bus.m_ack = 1'b1; bus.m_rdata = 32'hCAFE_0001;
    tick();
    bus.m_ack = 1'b0;
    check_resp("both_i_resp");
    bus.i_req = 1'b0;
    tick();

    // Timeout on a data load
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = MEM_SIZE_W; bus.d_addr = 32'h3000;
    sb.push_back('{1'b1, 32'h0, 1'b1});
    for (int c = 1; c <= int'(TIMEOUT); c++) begin
      tick();
      check("to_m_req_held", 64'(bus.m_req), 64'(1));
    end
    tick();
    check("to_m_req_drop", 64'(bus.m_req), 64'(0));
    check("to_no_ready",   64'(bus.d_ready), 64'(0));
    check("to_err_set",    64'(bus.d_err), 64'(1));
    tick();
    check_resp("to_resp");
    bus.d_req = 1'b0;
    tick();

    // Spurious ack in IDLE, then fetch with three wait states
    bus.m_ack = 1'b1; bus.m_rdata = 32'h0000_0BAD;
    tick();
    bus.m_ack = 1'b0; bus.m_rdata = '0;
    check("sp_no_i_ready", 64'(bus.i_ready), 64'(0));
    check("sp_no_d_ready", 64'(bus.d_ready), 64'(0));
    check("sp_no_m_req",   64'(bus.m_req), 64'(0));
    check("sp_rdata_hold", 64'(bus.i_rdata), 64'hCAFE_0001);
    bus.i_req = 1'b1; bus.i_addr = 32'h400;
    sb.push_back('{1'b0, 32'h0000_600D, 1'b0});
    tick();
    check("ws_m_req", 64'(bus.m_req), 64'(1));
    tick();
    tick();
    tick();
    check("ws_no_ready_c4", 64'(bus.i_ready), 64'(0));
    bus.m_ack = 1'b1; bus.m_rdata = 32'h0000_600D;
    tick();
    bus.m_ack = 1'b0; bus.m_rdata = '0;
    check_resp("ws_resp");
    bus.i_req = 1'b0;
    tick();

    // Async reset during BUSY_D abandons the transaction
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = MEM_SIZE_H; bus.d_addr = 32'h5000;
    tick();
    check("ar_m_req_busy", 64'(bus.m_req), 64'(1));
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("ar_m_req",   64'(bus.m_req), 64'(0));
    check("ar_m_addr",  64'(bus.m_addr), 64'(0));
    check("ar_m_size",  64'(bus.m_size), 64'(0));
    check("ar_d_ready", 64'(bus.d_ready), 64'(0));
    check("ar_d_err",   64'(bus.d_err), 64'(0));
    bus.d_req = 1'b0;
    tick();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("ar_no_d_ready", 64'(bus.d_ready), 64'(0));
      check("ar_idle_m_req", 64'(bus.m_req), 64'(0));
    end
    bus.i_req = 1'b1; bus.i_addr = 32'h600;
    sb.push_back('{1'b0, 32'h1111_2222, 1'b0});
    tick();
    check("ar_f_m_addr", 64'(bus.m_addr), 64'h600);
    bus.m_ack = 1'b1; bus.m_rdata = 32'h1111_2222;
    tick();
    bus.m_ack = 1'b0; bus.m_rdata = '0;
    check_resp("ar_f_resp");
    bus.i_req = 1'b0;
    tick();

    // Both requests held continuously: grant pattern
    bus.i_req = 1'b1; bus.i_addr = 32'h700;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = MEM_SIZE_W;
    bus.d_addr = 32'h7000; bus.d_wdata = 32'h1234_5678;
    for (int g = 0; g < 10; g++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      want_d = ((g % 5) != 4);
`else
      want_d = 1'b1;
`endif
      sb.push_back('{want_d, DATA_W'(32'hA000 + g), 1'b0});
      tick();
      check("st_m_req",  64'(bus.m_req), 64'(1));
      check("st_m_addr", 64'(bus.m_addr), want_d ? 64'h7000 : 64'h700);
      check("st_m_we",   64'(bus.m_we), 64'(want_d));
      bus.m_ack = 1'b1; bus.m_rdata = DATA_W'(32'hA000 + g);
      tick();
      bus.m_ack = 1'b0; bus.m_rdata = '0;
      check_resp("st_resp");
      tick();
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    tick();
    check("end_m_req", 64'(bus.m_req), 64'(0));
    check("end_sb_empty", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
